alarm_sequencer: RTL and testbench

- Anti-theft control FSM that sits on the controlling side of the seconds countdown timer.
- Drives the timer's load, enable and preset-seconds inputs, and consumes its expiry flag.
- Holds the four programmable time parameters, arbitrates door and ignition inputs, and drives the siren and a state code for the display/LED logic.

---
 rtl/alarm_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_alarm_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_sequencer.sv
// Anti-theft control FSM driving an external seconds countdown timer.
// Holds the four programmable delays and sequences arming, entry delay and siren.
module alarm_sequencer #(
    parameter logic [3:0] T_ARM       = 4'd6,
    parameter logic [3:0] T_DRIVER    = 4'd8,
    parameter logic [3:0] T_PASSENGER = 4'd15,
    parameter logic [3:0] T_ALARM     = 4'd10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ignition,
    input  logic       door_driver,
    input  logic       door_pass,
    input  logic       prog,
    input  logic [1:0] prog_sel,
    input  logic [3:0] prog_val,
    input  logic       timer_waited,
    output logic       timer_load,
    output logic       timer_en,
    output logic [3:0] t_default,
    output logic       siren,
    output logic [2:0] state_code
);

    typedef enum logic [2:0] {
        ST_ARMED      = 3'd0,
        ST_TRIGGERED  = 3'd1,
        ST_SOUND      = 3'd2,
        ST_DISARMED   = 3'd3,
        ST_WAIT_OPEN  = 3'd4,
        ST_WAIT_CLOSE = 3'd5,
        ST_ARM_DELAY  = 3'd6
    } state_t;

    localparam logic [1:0] SEL_ARM    = 2'd0;
    localparam logic [1:0] SEL_DRIVER = 2'd1;
    localparam logic [1:0] SEL_PASS   = 2'd2;
    localparam logic [1:0] SEL_ALARM  = 2'd3;

    function automatic logic is_timed(input state_t s);
        return (s == ST_TRIGGERED) || (s == ST_SOUND) || (s == ST_ARM_DELAY);
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    logic [1:0] isel_r;
    logic [1:0] isel_nxt_s;
    logic [3:0] arm_r;
    logic [3:0] driver_r;
    logic [3:0] pass_r;
    logic [3:0] alarm_r;
    logic       timer_load_r;
    logic       timer_en_r;
    logic       siren_r;
    logic       load_nxt_s;
    logic       en_nxt_s;
    logic       siren_nxt_s;
    logic       doors_s;
    logic       expired_s;
    logic       restart_s;
    logic       fresh_s;

    assign doors_s   = door_driver | door_pass;
    // Expiry only counts while the timer is actually enabled, never in a load cycle.
    assign expired_s = timer_waited & timer_en_r;

    // Programmable delay registers, written by the prog strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            arm_r    <= T_ARM;
            driver_r <= T_DRIVER;
            pass_r   <= T_PASSENGER;
            alarm_r  <= T_ALARM;
        end else if (prog) begin
            case (prog_sel)
                SEL_ARM:    arm_r    <= prog_val;
                SEL_DRIVER: driver_r <= prog_val;
                SEL_PASS:   pass_r   <= prog_val;
                SEL_ALARM:  alarm_r  <= prog_val;
                default:    arm_r    <= arm_r;
            endcase
        end else begin
            arm_r    <= arm_r;
            driver_r <= driver_r;
            pass_r   <= pass_r;
            alarm_r  <= alarm_r;
        end
    end

    // Next-state decision: prog overrides everything, then ignition, then per-state rules.
    always_comb begin
        state_nxt_s = state_r;
        if (prog) begin
            state_nxt_s = ST_ARMED;
        end else if (ignition && (state_r != ST_DISARMED)) begin
            state_nxt_s = ST_DISARMED;
        end else begin
            case (state_r)
                ST_ARMED: begin
                    if (doors_s) state_nxt_s = ST_TRIGGERED;
                    else         state_nxt_s = ST_ARMED;
                end
                ST_TRIGGERED: begin
                    if (expired_s) state_nxt_s = ST_SOUND;
                    else           state_nxt_s = ST_TRIGGERED;
                end
                ST_SOUND: begin
                    if (!doors_s && expired_s) state_nxt_s = ST_ARMED;
                    else                       state_nxt_s = ST_SOUND;
                end
                ST_DISARMED: begin
                    if (!ignition) state_nxt_s = ST_WAIT_OPEN;
                    else           state_nxt_s = ST_DISARMED;
                end
                ST_WAIT_OPEN: begin
                    if (door_driver) state_nxt_s = ST_WAIT_CLOSE;
                    else             state_nxt_s = ST_WAIT_OPEN;
                end
                ST_WAIT_CLOSE: begin
                    if (!doors_s) state_nxt_s = ST_ARM_DELAY;
                    else          state_nxt_s = ST_WAIT_CLOSE;
                end
                ST_ARM_DELAY: begin
                    if (doors_s)        state_nxt_s = ST_WAIT_CLOSE;
                    else if (expired_s) state_nxt_s = ST_ARMED;
                    else                state_nxt_s = ST_ARM_DELAY;
                end
                default: state_nxt_s = ST_ARMED;
            endcase
        end
    end

    // Interval select follows the state being entered; the entry door is latched on ARMED exit.
    always_comb begin
        isel_nxt_s = isel_r;
        case (state_nxt_s)
            ST_TRIGGERED: begin
                if (state_r == ST_ARMED) isel_nxt_s = door_driver ? SEL_DRIVER : SEL_PASS;
                else                     isel_nxt_s = isel_r;
            end
            ST_SOUND:     isel_nxt_s = SEL_ALARM;
            ST_ARM_DELAY: isel_nxt_s = SEL_ARM;
            default:      isel_nxt_s = isel_r;
        endcase
    end

    // Timer drive for the coming cycle: load on entry or SOUND restart, count otherwise.
    always_comb begin
        restart_s   = (state_r == ST_SOUND) && (state_nxt_s == ST_SOUND) && doors_s;
        fresh_s     = (state_nxt_s != state_r) || restart_s;
        load_nxt_s  = 1'b0;
        en_nxt_s    = 1'b0;
        siren_nxt_s = 1'b0;
        if (is_timed(state_nxt_s)) begin
            load_nxt_s = fresh_s;
            en_nxt_s   = !fresh_s;
        end else begin
            load_nxt_s = 1'b0;
            en_nxt_s   = 1'b0;
        end
        if (state_nxt_s == ST_SOUND) siren_nxt_s = 1'b1;
        else                         siren_nxt_s = 1'b0;
    end

    // State, interval select and registered output flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_ARMED;
            isel_r       <= SEL_ARM;
            timer_load_r <= 1'b0;
            timer_en_r   <= 1'b0;
            siren_r      <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            isel_r       <= isel_nxt_s;
            timer_load_r <= load_nxt_s;
            timer_en_r   <= en_nxt_s;
            siren_r      <= siren_nxt_s;
        end
    end

    // Preset seconds, decoded from the registered interval select.
    always_comb begin
        t_default = 4'd0;
        case (isel_r)
            SEL_ARM:    t_default = arm_r;
            SEL_DRIVER: t_default = driver_r;
            SEL_PASS:   t_default = pass_r;
            SEL_ALARM:  t_default = alarm_r;
            default:    t_default = arm_r;
        endcase
    end

    assign timer_load = timer_load_r;
    assign timer_en   = timer_en_r;
    assign siren      = siren_r;
    assign state_code = state_r;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: directed vector table, hand sequences for async reset,
// and random stimulus checked against a behavioural model of the alarm rules.
module tb_alarm_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       ignition, door_driver, door_pass, prog, timer_waited;
    logic [1:0] prog_sel;
    logic [3:0] prog_val;
    logic       timer_load, timer_en, siren;
    logic [3:0] t_default;
    logic [2:0] state_code;

    alarm_sequencer dut (
        .clock(clock), .reset(reset), .ignition(ignition),
        .door_driver(door_driver), .door_pass(door_pass), .prog(prog),
        .prog_sel(prog_sel), .prog_val(prog_val), .timer_waited(timer_waited),
        .timer_load(timer_load), .timer_en(timer_en), .t_default(t_default),
        .siren(siren), .state_code(state_code)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       ig, dd, dp, pg;
        logic [1:0] ps;
        logic [3:0] pv;
        logic       tw;
        logic [2:0] es;
        logic       el, ee, esi;
        logic [3:0] etd;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: state code, expected outputs and programmed delays.
    int m_state, m_int;
    logic m_load, m_en, m_siren;
    int m_par[4];

    function automatic vec_t mk(input int ig, dd, dp, pg, ps, pv, tw,
                                input int es, el, ee, esi, etd);
        vec_t v;
        v.ig = (ig != 0); v.dd = (dd != 0); v.dp = (dp != 0); v.pg = (pg != 0);
        v.ps = 2'(ps); v.pv = 4'(pv); v.tw = (tw != 0);
        v.es = 3'(es); v.el = (el != 0); v.ee = (ee != 0); v.esi = (esi != 0);
        v.etd = 4'(etd);
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_int = 0; m_load = 1'b0; m_en = 1'b0; m_siren = 1'b0;
        m_par[0] = 6; m_par[1] = 8; m_par[2] = 15; m_par[3] = 10;
    endtask

    task automatic model_step(input vec_t v);
        bit expired, door, timed, fresh;
        int nxt;
        expired = v.tw && m_en;
        door    = v.dd || v.dp;
        nxt     = m_state;
        if (v.pg) begin
            m_par[v.ps] = int'(v.pv);
            nxt = 0;
        end else if (v.ig && m_state != 3) begin
            nxt = 3;
        end else begin
            case (m_state)
                0: if (v.dd) begin nxt = 1; m_int = 1; end
                   else if (v.dp) begin nxt = 1; m_int = 2; end
                1: if (expired) nxt = 2;
                2: if (!door && expired) nxt = 0;
                3: if (!v.ig) nxt = 4;
                4: if (v.dd) nxt = 5;
                5: if (!door) nxt = 6;
                6: if (door) nxt = 5; else if (expired) nxt = 0;
                default: nxt = 0;
            endcase
        end
        if (nxt == 2) m_int = 3;
        if (nxt == 6) m_int = 0;
        timed   = (nxt == 1) || (nxt == 2) || (nxt == 6);
        fresh   = (nxt != m_state) || (nxt == 2 && door);
        m_load  = timed && fresh;
        m_en    = timed && !fresh;
        m_siren = (nxt == 2);
        m_state = nxt;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input logic [2:0] es, input logic el, ee, esi,
                       input logic [3:0] etd);
        chk({tag, " state_code"}, 8'(state_code), 8'(es));
        chk({tag, " timer_load"}, 8'(timer_load), 8'(el));
        chk({tag, " timer_en"},   8'(timer_en),   8'(ee));
        chk({tag, " siren"},      8'(siren),      8'(esi));
        if (el) chk({tag, " t_default"}, 8'(t_default), 8'(etd));
    endtask

    // Drive one vector on the falling edge, advance the model at the rising edge.
    task automatic step(input vec_t v);
        @(negedge clock);
        ignition = v.ig; door_driver = v.dd; door_pass = v.dp; prog = v.pg;
        prog_sel = v.ps; prog_val = v.pv; timer_waited = v.tw;
        @(posedge clock);
        model_step(v);
        #1;
    endtask

    task automatic run(input string tag, input vec_t v);
        step(v);
        cmp(tag, v.es, v.el, v.ee, v.esi, v.etd);
    endtask

    vec_t tbl[$];
    logic r_ig, r_dd, r_dp;

    initial begin
        reset = 1'b1; ignition = 1'b0; door_driver = 1'b0; door_pass = 1'b0;
        prog = 1'b0; prog_sel = 2'd0; prog_val = 4'd0; timer_waited = 1'b0;
        model_reset();
        #3;
        cmp("reset", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        #9 reset = 1'b0;

        //           ig dd dp pg ps pv tw   es el ee si td
        tbl.push_back(mk(0,1,0, 0,0,0, 0,   1,1,0,0, 8));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,   1,0,1,0, 0));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,   2,1,0,1,10));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,   2,0,1,1, 0));
        for (int i = 0; i < 20; i++)
            tbl.push_back(mk(0,0,1, 0,0,0, i % 2, 2,1,0,1,10));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,   2,0,1,1, 0));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,   0,0,0,0, 0));
        tbl.push_back(mk(1,0,0, 0,0,0, 0,   3,0,0,0, 0));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,   4,0,0,0, 0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,   5,0,0,0, 0));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,   6,1,0,0, 6));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,   6,0,1,0, 0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,   5,0,0,0, 0));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,   6,1,0,0, 6));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,   6,0,1,0, 0));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,   0,0,0,0, 0));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,   0,0,0,0, 0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,   1,1,0,0, 8));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,   1,0,1,0, 0));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,   2,1,0,1,10));
        tbl.push_back(mk(0,0,0, 1,1,3, 0,   0,0,0,0, 0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,   1,1,0,0, 3));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,   1,0,1,0, 0));
        tbl.push_back(mk(0,0,0, 1,1,8, 0,   0,0,0,0, 0));
        tbl.push_back(mk(0,1,1, 0,0,0, 0,   1,1,0,0, 8));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,   1,0,1,0, 0));
        tbl.push_back(mk(1,0,0, 0,0,0, 0,   3,0,0,0, 0));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,   4,0,0,0, 0));
        tbl.push_back(mk(0,0,1, 0,0,0, 0,   4,0,0,0, 0));
        tbl.push_back(mk(0,0,0, 1,3,0, 0,   0,0,0,0, 0));
        tbl.push_back(mk(0,0,1, 0,0,0, 0,   1,1,0,0,15));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,   1,0,1,0, 0));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,   2,1,0,1, 0));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,   2,0,1,1, 0));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,   0,0,0,0, 0));
        tbl.push_back(mk(0,0,0, 1,3,10,0,   0,0,0,0, 0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,   1,1,0,0, 8));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,   1,0,1,0, 0));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,   2,1,0,1,10));
        tbl.push_back(mk(1,0,0, 0,0,0, 0,   3,0,0,0, 0));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,   4,0,0,0, 0));

        for (int i = 0; i < tbl.size(); i++)
            run($sformatf("vec%0d", i), tbl[i]);

        // ARM reprogrammed, then async reset mid ARM_DELAY restores defaults.
        run("ar_prog",  mk(0,0,0, 1,0,2, 0, 0,0,0,0, 0));
        run("ar_ign",   mk(1,0,0, 0,0,0, 0, 3,0,0,0, 0));
        run("ar_off",   mk(0,0,0, 0,0,0, 0, 4,0,0,0, 0));
        run("ar_open",  mk(0,1,0, 0,0,0, 0, 5,0,0,0, 0));
        run("ar_close", mk(0,0,0, 0,0,0, 0, 6,1,0,0, 2));
        run("ar_count", mk(0,0,0, 0,0,0, 0, 6,0,1,0, 0));
        #1 reset = 1'b1;
        #1;
        cmp("async_reset", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        model_reset();
        #5 reset = 1'b0;
        run("rs_ign",   mk(1,0,0, 0,0,0, 0, 3,0,0,0, 0));
        run("rs_off",   mk(0,0,0, 0,0,0, 0, 4,0,0,0, 0));
        run("rs_open",  mk(0,1,0, 0,0,0, 0, 5,0,0,0, 0));
        run("rs_close", mk(0,0,0, 0,0,0, 0, 6,1,0,0, 6));

        // Random stimulus against the model; doors and ignition are sticky.
        r_ig = 1'b0; r_dd = 1'b0; r_dp = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            vec_t v;
            if ($urandom_range(0, 15) == 0) r_ig = ~r_ig;
            if ($urandom_range(0, 5) == 0)  r_dd = ~r_dd;
            if ($urandom_range(0, 5) == 0)  r_dp = ~r_dp;
            v = mk(int'(r_ig), int'(r_dd), int'(r_dp),
                   int'($urandom_range(0, 39) == 0), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 2) == 0),
                   0, 0, 0, 0, 0);
            step(v);
            cmp($sformatf("rand%0d", i), 3'(m_state), m_load, m_en, m_siren,
                4'(m_par[m_int]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
